// File: rtl/alarm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_pkg                                                    |
// | Description : Shared types and constants for the anti-theft alarm          |
// |               sequencer: interval codes, state encoding, value width.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package alarm_pkg;

  // Width of a time_parameters value, in seconds.
  localparam int VALUE_W = 4;

  // Interval selector codes presented to the time_parameters store.
  localparam logic [1:0] T_ARM_DELAY       = 2'b00;
  localparam logic [1:0] T_DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] T_PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] T_ALARM_ON        = 2'b11;

  // Sequencer states; the encoding is exported on state_dbg.
  typedef enum logic [2:0] {
    ST_ARMED      = 3'd0,
    ST_TRIGGERED  = 3'd1,
    ST_SOUND      = 3'd2,
    ST_DISARMED   = 3'd3,
    ST_WAIT_OPEN  = 3'd4,
    ST_WAIT_CLOSE = 3'd5,
    ST_ARM_WAIT   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alarm_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_timer                                                  |
// | Description : Seconds countdown for the alarm sequencer. A load request    |
// |               arms a one-cycle load slot; the count is captured from value |
// |               in that slot and then decremented on every 1 Hz tick.        |
// | Ports       : clock, reset (async, active-low), clear (abort countdown),   |
// |               load (start request), tick (1 Hz), value (seconds),          |
// |               expired (1-cycle pulse on final tick), busy (in flight).     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alarm_timer
  import alarm_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic               tick,
  input  logic [VALUE_W-1:0] value,
  output logic               expired,
  output logic               busy
);

  logic               load_pending;
  logic               active;
  logic [VALUE_W-1:0] count;

  // A count of 1 expires on its tick; a loaded 0 is treated the same way so it
  // expires on the first tick instead of underflowing. Ticks in the load slot
  // are not counted.
  assign expired = active && !load_pending && tick && (count <= VALUE_W'(1));
  assign busy    = active || load_pending;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_pending <= 1'b0;
      active       <= 1'b0;
      count        <= '0;
    end else if (clear) begin
      load_pending <= 1'b0;
      active       <= 1'b0;
      count        <= '0;
    end else begin
      if (load_pending) begin
        count  <= value;
        active <= 1'b1;
      end else if (active && tick) begin
        if (count != '0) begin
          count <= count - VALUE_W'(1);
        end
        if (count <= VALUE_W'(1)) begin
          active <= 1'b0;
        end
      end
      load_pending <= load;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alarm_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_controller                                             |
// | Description : Anti-theft alarm sequencer. Chooses the active interval,     |
// |               runs its countdown on the 1 Hz enable and drives the siren   |
// |               and status LED from ignition, door and reprogram inputs.     |
// | Ports       : clock, reset (async, active-low), ignition, door_driver,     |
// |               door_pass, reprogram, one_hz_enable, value[3:0] in;          |
// |               interval[1:0], siren, status_led, state_dbg[2:0] out.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int BLINK_TICKS = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic               door_driver,
  input  logic               door_pass,
  input  logic               reprogram,
  input  logic               one_hz_enable,
  input  logic [VALUE_W-1:0] value,
  output logic [1:0]         interval,
  output logic               siren,
  output logic               status_led,
  output logic [2:0]         state_dbg
);

  localparam int                 BLINK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  state_t             state, state_nx;
  logic [1:0]         interval_nx;
  logic               siren_nx;
  logic               led_nx;
  logic [BLINK_W-1:0] blink, blink_nx;
  logic               start;
  logic [1:0]         start_code;
  logic               expired;
  logic               busy;
  logic               timer_done;

  alarm_timer u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (reprogram),
    .load    (start),
    .tick    (one_hz_enable),
    .value   (value),
    .expired (expired),
    .busy    (busy)
  );

  // Only act on an expiry that belongs to a countdown still in flight.
  assign timer_done = expired && busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_ARMED;
      interval   <= T_ARM_DELAY;
      siren      <= 1'b0;
      status_led <= 1'b0;
      blink      <= '0;
    end else begin
      state      <= state_nx;
      interval   <= interval_nx;
      siren      <= siren_nx;
      status_led <= led_nx;
      blink      <= blink_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    start       = 1'b0;
    start_code  = interval;
    interval_nx = interval;
    siren_nx    = 1'b0;
    led_nx      = 1'b0;
    blink_nx    = '0;

    if (reprogram) begin
      state_nx = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED: begin
          if (ignition) begin
            state_nx = ST_DISARMED;
          end else if (door_driver) begin
            state_nx   = ST_TRIGGERED;
            start      = 1'b1;
            start_code = T_DRIVER_DELAY;
          end else if (door_pass) begin
            state_nx   = ST_TRIGGERED;
            start      = 1'b1;
            start_code = T_PASSENGER_DELAY;
          end
        end
        ST_TRIGGERED: begin
          if (ignition) begin
            state_nx = ST_DISARMED;
          end else if (timer_done) begin
            state_nx   = ST_SOUND;
            start      = 1'b1;
            start_code = T_ALARM_ON;
          end
        end
        ST_SOUND: begin
          if (ignition) begin
            state_nx = ST_DISARMED;
          end else if (door_driver || door_pass) begin
            // Keep reloading so the alarm period only starts once closed.
            start      = 1'b1;
            start_code = T_ALARM_ON;
          end else if (timer_done) begin
            state_nx = ST_ARMED;
          end
        end
        ST_DISARMED: begin
          if (!ignition) begin
            state_nx = ST_WAIT_OPEN;
          end
        end
        ST_WAIT_OPEN: begin
          if (ignition) begin
            state_nx = ST_DISARMED;
          end else if (door_driver) begin
            state_nx = ST_WAIT_CLOSE;
          end
        end
        ST_WAIT_CLOSE: begin
          if (ignition) begin
            state_nx = ST_DISARMED;
          end else if (!door_driver && !door_pass) begin
            state_nx   = ST_ARM_WAIT;
            start      = 1'b1;
            start_code = T_ARM_DELAY;
          end
        end
        ST_ARM_WAIT: begin
          if (ignition) begin
            state_nx = ST_DISARMED;
          end else if (door_driver || door_pass) begin
            state_nx = ST_WAIT_CLOSE;
          end else if (timer_done) begin
            state_nx = ST_ARMED;
          end
        end
        default: state_nx = ST_ARMED;
      endcase
    end

    if (reprogram) begin
      interval_nx = T_ARM_DELAY;
    end else if (start) begin
      interval_nx = start_code;
    end

    siren_nx = (state_nx == ST_SOUND);

    // Blink phase restarts on every entry into ARMED, including a reprogram
    // issued while already ARMED.
    if (state_nx == ST_ARMED) begin
      if (state == ST_ARMED && !reprogram) begin
        led_nx   = status_led;
        blink_nx = blink;
        if (one_hz_enable) begin
          if (blink == BLINK_LAST) begin
            blink_nx = '0;
            led_nx   = ~status_led;
          end else begin
            blink_nx = blink + BLINK_W'(1);
          end
        end
      end
    end else begin
      led_nx = (state_nx == ST_TRIGGERED) || (state_nx == ST_SOUND);
    end
  end

  assign state_dbg = state;

endmodule
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alarm_controller                                          |
// | Description : Scoreboard bench for alarm_controller. A behavioural model   |
// |               predicts the registered outputs for every clock; a monitor   |
// |               compares them one time unit after each rising edge.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_alarm_controller;

  localparam int BLINK = 1;

  // Model state numbering follows the state_dbg encoding.
  localparam int M_ARMED = 0, M_TRIG = 1, M_SOUND = 2, M_DIS = 3,
                 M_WOPEN = 4, M_WCLOSE = 5, M_AWAIT = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ignition = 1'b0, door_driver = 1'b0, door_pass = 1'b0;
  logic       reprogram = 1'b0, one_hz_enable = 1'b0;
  logic [3:0] value;
  logic [1:0] interval;
  logic       siren, status_led;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  // time_parameters stand-in with default settings.
  always_comb begin
    case (interval)
      2'd0:    value = 4'd6;
      2'd1:    value = 4'd8;
      2'd2:    value = 4'd15;
      default: value = 4'd10;
    endcase
  end

  alarm_controller #(.BLINK_TICKS(BLINK)) dut (
    .clock         (clock),
    .reset         (reset),
    .ignition      (ignition),
    .door_driver   (door_driver),
    .door_pass     (door_pass),
    .reprogram     (reprogram),
    .one_hz_enable (one_hz_enable),
    .value         (value),
    .interval      (interval),
    .siren         (siren),
    .status_led    (status_led),
    .state_dbg     (state_dbg)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] iv;
    logic       sr;
    logic       led;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // ---------------- reference model ----------------
  int m_mode, m_intv, m_ticks_left, m_since_armed;
  bit m_load_next, m_counting;

  function automatic int secs(input int code);
    case (code)
      0: return 6;
      1: return 8;
      2: return 15;
      default: return 10;
    endcase
  endfunction

  function automatic void model_step(input bit rn, ig, d1, d2, rp, tk);
    int nxt, code;
    bit fire, any_door;
    if (!rn) begin
      m_mode = M_ARMED; m_intv = 0; m_load_next = 0; m_counting = 0;
      m_ticks_left = 0; m_since_armed = 0;
      return;
    end
    any_door = d1 || d2;
    // A countdown of N seconds needs N counted ticks (at least one).
    fire = m_counting && !m_load_next && tk && (m_ticks_left == 1);
    nxt = m_mode;
    code = -1;
    if (rp) nxt = M_ARMED;
    else if (ig && m_mode != M_ARMED && m_mode != M_DIS) nxt = M_DIS;
    else begin
      case (m_mode)
        M_ARMED:  if (ig) nxt = M_DIS;
                  else if (d1) begin nxt = M_TRIG; code = 1; end
                  else if (d2) begin nxt = M_TRIG; code = 2; end
        M_TRIG:   if (fire) begin nxt = M_SOUND; code = 3; end
        M_SOUND:  if (any_door) code = 3;
                  else if (fire) nxt = M_ARMED;
        M_DIS:    if (!ig) nxt = M_WOPEN;
        M_WOPEN:  if (d1) nxt = M_WCLOSE;
        M_WCLOSE: if (!any_door) begin nxt = M_AWAIT; code = 0; end
        M_AWAIT:  if (any_door) nxt = M_WCLOSE;
                  else if (fire) nxt = M_ARMED;
        default:  nxt = M_ARMED;
      endcase
    end
    if (rp) begin
      m_load_next = 0; m_counting = 0; m_ticks_left = 0; m_intv = 0;
    end else begin
      if (m_load_next) begin
        m_ticks_left = (secs(m_intv) < 1) ? 1 : secs(m_intv);
        m_counting = 1;
      end else if (m_counting && tk) begin
        m_ticks_left--;
        if (m_ticks_left == 0) m_counting = 0;
      end
      m_load_next = (code >= 0);
      if (code >= 0) m_intv = code;
    end
    if (nxt == M_ARMED) begin
      if (m_mode != M_ARMED || rp) m_since_armed = 0;
      else if (tk) m_since_armed++;
    end
    m_mode = nxt;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st  = 3'(m_mode);
    e.iv  = 2'(m_intv);
    e.sr  = (m_mode == M_SOUND);
    if (m_mode == M_ARMED) e.led = ((m_since_armed / BLINK) % 2) == 1;
    else e.led = (m_mode == M_TRIG) || (m_mode == M_SOUND);
    return e;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input bit rn, ig, d1, d2, rp, tk);
    @(negedge clock);
    reset = rn; ignition = ig; door_driver = d1; door_pass = d2;
    reprogram = rp; one_hz_enable = tk;
    model_step(rn, ig, d1, d2, rp, tk);
    sb.push_back(model_out());
    cyc++;
  endtask

  // Directed phases tick once every four clocks.
  task automatic hold(input int n, input bit ig, d1, d2);
    for (int i = 0; i < n; i++) step(1'b1, ig, d1, d2, 1'b0, (cyc % 4) == 0);
  endtask

  task automatic ticks(input int k, input bit ig, d1, d2);
    hold(4 * k, ig, d1, d2);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        tests++;
        if (state_dbg !== e.st || interval !== e.iv || siren !== e.sr || status_led !== e.led) begin
          fails++;
          $display("FAIL outputs t=%0t: state/interval/siren/led got %0d/%0d/%0b/%0b required %0d/%0d/%0b/%0b",
                   $time, state_dbg, interval, siren, status_led, e.st, e.iv, e.sr, e.led);
        end
      end
    end
  end

  initial begin
    bit ig, d1, d2;
    // Reset and blink after release.
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1'b1, 0, 0, 0, 0, 1);
    // Reset mid-run while blinking.
    step(1'b0, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0, 0);
    ticks(3, 0, 0, 0);

    // Driver door pulse: 8-tick delay, then 10-tick alarm.
    hold(1, 0, 1, 0);
    ticks(9, 0, 0, 0);
    ticks(12, 0, 0, 0);

    // Both doors together: driver code wins.
    hold(1, 0, 1, 1);
    ticks(20, 0, 0, 0);
    // Passenger door alone: 15-tick delay.
    hold(1, 0, 0, 1);
    ticks(27, 0, 0, 0);

    // Door held open during SOUND.
    hold(1, 0, 1, 0);
    ticks(9, 0, 0, 0);
    ticks(20, 0, 1, 0);
    ticks(12, 0, 0, 0);

    // Ignition during TRIGGERED, then the re-arm sequence.
    hold(1, 0, 1, 0);
    ticks(5, 0, 0, 0);
    hold(6, 1, 0, 0);
    hold(3, 0, 0, 0);
    hold(3, 0, 1, 0);
    hold(1, 0, 0, 0);
    ticks(8, 0, 0, 0);

    // ARM_WAIT interrupted by a reopened door, then a full restart.
    hold(3, 1, 0, 0);
    hold(2, 0, 0, 0);
    hold(2, 0, 1, 0);
    ticks(3, 0, 0, 0);
    hold(2, 0, 0, 1);
    ticks(8, 0, 0, 0);

    // Reprogram in SOUND.
    hold(1, 0, 1, 0);
    ticks(10, 0, 0, 0);
    step(1'b1, 0, 0, 0, 1, 0);
    ticks(3, 0, 0, 0);

    // Asynchronous reset mid-countdown.
    hold(1, 0, 0, 1);
    ticks(4, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 1);
    step(1'b1, 0, 0, 0, 0, 1);
    ticks(20, 0, 0, 0);

    // Randomised level-held inputs.
    ig = 0; d1 = 0; d2 = 0;
    for (int i = 0; i < 4000; i++) begin
      if (ig) begin if ($urandom_range(0, 7) == 0) ig = ~ig; end
      else if ($urandom_range(0, 59) == 0) ig = 1'b1;
      if ($urandom_range(0, 11) == 0) d1 = ~d1;
      if ($urandom_range(0, 13) == 0) d2 = ~d2;
      step($urandom_range(0, 1499) != 0, ig, d1, d2,
           $urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0);
    end

    @(posedge clock);
    @(posedge clock);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
